program_loader_ctrl: RTL and testbench

- Boot/run sequencer for the byte-loaded CPU core.
- Accepts a program as a byte stream over a valid/ready handshake and writes it into program memory through the core's pmWrEn / pmAddr / instructionIn port.
- Holds the core in reset while loading and settling, then releases it for a programmed number of cycles (or until stopped), then re-asserts core reset and reports completion.

---
 rtl/program_loader_ctrl.sv | 160 ++++++++++++++++
 tb/tb_program_loader_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader_ctrl.sv
// Boot/run sequencer for the byte-loaded CPU core.
// Streams a program into program memory over a valid/ready handshake, holds the
// core in reset while loading and settling, runs it for a programmed number of
// cycles (or until stopped), then puts it back in reset and reports completion.
module program_loader_ctrl #(
    parameter int ADDWIDTH      = 7,
    parameter int RUNWIDTH      = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDWIDTH:0]   len,
    input  logic [RUNWIDTH-1:0] runCycles,
    input  logic                stop,
    input  logic [7:0]          byteIn,
    input  logic                byteValid,
    output logic                byteReady,
    output logic                pmWrEn,
    output logic [ADDWIDTH-1:0] pmAddr,
    output logic [7:0]          pmData,
    output logic                cpuRst,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN} state_t;

    localparam int                  SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ADDWIDTH:0]   MAX_LEN     = {1'b1, {ADDWIDTH{1'b0}}};
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t              state, state_d;
    logic [ADDWIDTH:0]   len_q, len_d;
    logic [RUNWIDTH-1:0] limit_q, limit_d;
    logic [ADDWIDTH-1:0] byte_cnt, byte_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt, settle_cnt_d;
    logic [RUNWIDTH-1:0] run_cnt, run_cnt_d;
    logic                wr_en_d;
    logic [ADDWIDTH-1:0] addr_d;
    logic [7:0]          data_d;
    logic                cpu_rst_d, busy_d, done_d, err_d;
    logic                handshake;

    // The loader is ready exactly while in LOAD; this is the only unregistered output.
    assign byteReady = (state == S_LOAD);
    assign handshake = byteValid & byteReady;

    // Next-state, counter and registered-output decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves
        // one unassigned and no latch is inferred.
        state_d      = state;
        len_d        = len_q;
        limit_d      = limit_q;
        byte_cnt_d   = byte_cnt;
        settle_cnt_d = settle_cnt;
        run_cnt_d    = run_cnt;
        wr_en_d      = 1'b0;
        addr_d       = pmAddr;
        data_d       = pmData;
        done_d       = 1'b0;
        err_d        = 1'b0;

        unique case (state)
            S_IDLE: begin
                // A start in the same cycle as a done/err pulse is not honoured.
                if (start && !done && !err) begin
                    if (len == '0 || len > MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        len_d      = len;
                        limit_d    = runCycles;
                        byte_cnt_d = '0;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                // stop wins over a same-cycle handshake: that byte is dropped.
                if (stop) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (handshake) begin
                    wr_en_d = 1'b1;
                    addr_d  = byte_cnt;
                    data_d  = byteIn;
                    if ({1'b0, byte_cnt} == len_q - 1'b1) begin
                        settle_cnt_d = '0;
                        state_d      = S_SETTLE;
                    end else begin
                        byte_cnt_d = byte_cnt + 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (stop) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    run_cnt_d = '0;
                    state_d   = S_RUN;
                end else begin
                    settle_cnt_d = settle_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // A zero limit means run until stopped.
                if (stop || (limit_q != '0 && run_cnt == limit_q - 1'b1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    run_cnt_d = run_cnt + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered from the next state so they line up with the state itself.
        cpu_rst_d = (state_d != S_RUN);
        busy_d    = (state_d != S_IDLE);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state      <= S_IDLE;
            len_q      <= '0;
            limit_q    <= '0;
            byte_cnt   <= '0;
            settle_cnt <= '0;
            run_cnt    <= '0;
            pmWrEn     <= 1'b0;
            pmAddr     <= '0;
            pmData     <= '0;
            cpuRst     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            len_q      <= len_d;
            limit_q    <= limit_d;
            byte_cnt   <= byte_cnt_d;
            settle_cnt <= settle_cnt_d;
            run_cnt    <= run_cnt_d;
            pmWrEn     <= wr_en_d;
            pmAddr     <= addr_d;
            pmData     <= data_d;
            cpuRst     <= cpu_rst_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_program_loader_ctrl.sv
// Self-checking bench for program_loader_ctrl: a session-level reference model
// predicts every output each cycle, directed scenarios pin the model with
// hand-computed counts, and a randomized phase exercises mixed traffic.
module tb_program_loader_ctrl;

    localparam int DEPTH  = 128;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [15:0] runCycles = '0;
    logic        stop = 1'b0;
    logic [7:0]  byteIn = '0;
    logic        byteValid = 1'b0;
    logic        byteReady, pmWrEn, cpuRst, busy, done, err;
    logic [6:0]  pmAddr;
    logic [7:0]  pmData;

    program_loader_ctrl #(.ADDWIDTH(7), .RUNWIDTH(16), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .runCycles(runCycles),
        .stop(stop), .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
        .pmWrEn(pmWrEn), .pmAddr(pmAddr), .pmData(pmData), .cpuRst(cpuRst),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- session-level reference model ----------------
    // A session is described by how many bytes, settle cycles and run cycles remain;
    // the phase is implied by which of those is still outstanding.
    bit         active = 1'b0;
    int         bytes_left = 0, settle_left = 0, run_left = 0, next_addr = 0;
    logic       e_wr = 1'b0, e_done = 1'b0, e_err = 1'b0, e_busy = 1'b0;
    logic       e_ready = 1'b0, e_cpurst = 1'b1;
    logic [6:0] e_addr = '0;
    logic [7:0] e_data = '0;

    task automatic model_step();
        logic nw, nd, ne;
        nw = 1'b0; nd = 1'b0; ne = 1'b0;
        if (rst) begin
            active = 1'b0; bytes_left = 0; settle_left = 0; run_left = 0;
            e_addr = '0; e_data = '0;
        end else if (!active) begin
            if (start && !e_done && !e_err) begin
                if (int'(len) == 0 || int'(len) > DEPTH) ne = 1'b1;
                else begin
                    active = 1'b1; bytes_left = int'(len); settle_left = SETTLE;
                    run_left = int'(runCycles); next_addr = 0;
                end
            end
        end else if (bytes_left > 0) begin
            if (stop) begin active = 1'b0; ne = 1'b1; end
            else if (byteValid) begin
                nw = 1'b1; e_addr = 7'(next_addr); e_data = byteIn;
                next_addr++; bytes_left--;
            end
        end else if (settle_left > 0) begin
            if (stop) begin active = 1'b0; nd = 1'b1; end
            else settle_left--;
        end else begin
            if (stop) begin active = 1'b0; nd = 1'b1; end
            else if (run_left != 0) begin
                run_left--;
                if (run_left == 0) begin active = 1'b0; nd = 1'b1; end
            end
        end
        e_wr = nw; e_done = nd; e_err = ne;
        e_busy   = active;
        e_ready  = active && bytes_left > 0;
        e_cpurst = !(active && bytes_left == 0 && settle_left == 0);
    endtask

    // Advance the model on the same edge the DUT samples its inputs.
    always @(posedge clk) model_step();

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("byteReady", 32'(byteReady), 32'(e_ready));
            check("pmWrEn",    32'(pmWrEn),    32'(e_wr));
            check("pmAddr",    32'(pmAddr),    32'(e_addr));
            check("pmData",    32'(pmData),    32'(e_data));
            check("cpuRst",    32'(cpuRst),    32'(e_cpurst));
            check("busy",      32'(busy),      32'(e_busy));
            check("done",      32'(done),      32'(e_done));
            check("err",       32'(err),       32'(e_err));
        end
    end

    // ---------------- observation statistics for directed tests ----------------
    int         n_wr, n_run, n_settle, n_done, n_err, n_busy, n_done_bad;
    logic [6:0] last_addr;
    logic [7:0] obs_mem [DEPTH];

    task automatic reset_stats();
        n_wr = 0; n_run = 0; n_settle = 0; n_done = 0; n_err = 0; n_busy = 0;
        n_done_bad = 0; last_addr = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (pmWrEn === 1'b1) begin n_wr++; obs_mem[pmAddr] = pmData; last_addr = pmAddr; end
        if (cpuRst === 1'b0) n_run++;
        if (busy === 1'b1 && cpuRst === 1'b1 && byteReady === 1'b0) n_settle++;
        if (done === 1'b1) begin n_done++; if (cpuRst !== 1'b1) n_done_bad++; end
        if (err === 1'b1) n_err++;
        if (busy === 1'b1) n_busy++;
    endtask

    task automatic wait_idle(input string name, input int max_cycles);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin tick(); n++; end
        check(name, 32'(busy), 0);
        tick();  // step past the done/err cycle
    endtask

    task automatic begin_session(input int l, input int rc);
        start = 1'b1; len = 8'(l); runCycles = 16'(rc);
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byteReady"}, 32'(byteReady), 0);
        check({tag, "_pmWrEn"},    32'(pmWrEn),    0);
        check({tag, "_pmAddr"},    32'(pmAddr),    0);
        check({tag, "_pmData"},    32'(pmData),    0);
        check({tag, "_cpuRst"},    32'(cpuRst),    1);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_done"},      32'(done),      0);
        check({tag, "_err"},       32'(err),       0);
    endtask

    logic [7:0] t1_bytes [4];
    logic [7:0] t2_bytes [3];

    initial begin
        reset_stats();
        tick(); tick(); tick();
        cmp_en = 1'b1;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Load with no backpressure, 5-cycle run.
        t1_bytes[0] = 8'h13; t1_bytes[1] = 8'h22; t1_bytes[2] = 8'h31; t1_bytes[3] = 8'h40;
        reset_stats();
        begin_session(4, 5);
        for (int i = 0; i < 4; i++) begin byteValid = 1'b1; byteIn = t1_bytes[i]; tick(); end
        byteValid = 1'b0;
        wait_idle("t1_timeout", 50);
        check("t1_writes", 32'(n_wr), 4);
        for (int i = 0; i < 4; i++) check("t1_mem", 32'(obs_mem[i]), 32'(t1_bytes[i]));
        check("t1_settle_cycles", 32'(n_settle), 2);
        check("t1_run_cycles", 32'(n_run), 5);
        check("t1_done_pulses", 32'(n_done), 1);
        check("t1_done_cpurst", 32'(n_done_bad), 0);

        // Gapped valid pattern 1,0,0,1,0,1.
        begin
            logic [5:0] pat;
            int k;
            pat = 6'b101001;
            k = 0;
            t2_bytes[0] = 8'hA5; t2_bytes[1] = 8'h5A; t2_bytes[2] = 8'hC3;
            reset_stats();
            begin_session(3, 2);
            for (int i = 0; i < 6; i++) begin
                byteValid = pat[i];
                byteIn = t2_bytes[k < 3 ? k : 2];
                tick();
                if (pat[i]) k++;
            end
            byteValid = 1'b0;
            check("t2_ready_drop", 32'(byteReady), 0);
            check("t2_writes", 32'(n_wr), 3);
            check("t2_last_addr", 32'(last_addr), 2);
            for (int i = 0; i < 3; i++) check("t2_mem", 32'(obs_mem[i]), 32'(t2_bytes[i]));
            wait_idle("t2_timeout", 50);
        end

        // Illegal lengths, then the full-depth program.
        reset_stats();
        begin_session(0, 3);
        tick();
        begin_session(129, 3);
        tick();
        check("t3_err_pulses", 32'(n_err), 2);
        check("t3_busy_cycles", 32'(n_busy), 0);
        check("t3_no_writes", 32'(n_wr), 0);
        reset_stats();
        begin_session(128, 1);
        for (int i = 0; i < 128; i++) begin byteValid = 1'b1; byteIn = 8'(i * 7 + 3); tick(); end
        byteValid = 1'b0;
        wait_idle("t3_timeout", 50);
        check("t3_writes", 32'(n_wr), 128);
        check("t3_last_addr", 32'(last_addr), 127);
        check("t3_mem_first", 32'(obs_mem[0]), 32'h03);
        check("t3_mem_last", 32'(obs_mem[127]), 32'h7C);

        // Abort during load on the same cycle as a 4th handshake.
        reset_stats();
        begin_session(8, 3);
        for (int i = 0; i < 3; i++) begin byteValid = 1'b1; byteIn = 8'(8'h60 + i); tick(); end
        byteIn = 8'hEE; stop = 1'b1;
        tick();
        stop = 1'b0; byteValid = 1'b0;
        tick();
        check("t4_writes", 32'(n_wr), 3);
        check("t4_last_addr", 32'(last_addr), 2);
        check("t4_err", 32'(n_err), 1);
        check("t4_done", 32'(n_done), 0);
        check("t4_cpu_never_run", 32'(n_run), 0);

        // Unlimited run ended by stop.
        begin_session(2, 0);
        for (int i = 0; i < 2; i++) begin byteValid = 1'b1; byteIn = 8'(8'h70 + i); tick(); end
        byteValid = 1'b0;
        reset_stats();
        for (int i = 0; i < 101; i++) tick();
        check("t5_run_cycles", 32'(n_run), 100);
        check("t5_settle_tail", 32'(n_settle), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_stop_cpurst", 32'(cpuRst), 1);
        check("t5_stop_done", 32'(done), 1);
        check("t5_stop_busy", 32'(busy), 0);
        tick();

        // Reset mid-load and mid-run; starts while busy are ignored.
        begin_session(6, 4);
        byteValid = 1'b1; byteIn = 8'h11; start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0; byteIn = 8'h22;
        tick();
        byteValid = 1'b0; rst = 1'b1;
        tick();
        check_reset_outputs("t6_load_rst");
        rst = 1'b0;
        begin_session(2, 0);
        for (int i = 0; i < 2; i++) begin byteValid = 1'b1; byteIn = 8'(8'h90 + i); tick(); end
        byteValid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b1; len = 8'd3; runCycles = 16'd1;
        tick();
        start = 1'b0;
        check("t6_start_ignored", 32'(cpuRst), 0);
        rst = 1'b1;
        tick();
        check_reset_outputs("t6_run_rst");
        rst = 1'b0;
        tick();

        // Randomized mixed traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            int r;
            r = int'($urandom % 16);
            case (r)
                0:       len = 8'd0;
                1:       len = 8'($urandom_range(129, 255));
                2:       len = 8'd128;
                default: len = 8'($urandom_range(1, 6));
            endcase
            start     = ($urandom % 8) == 0;
            runCycles = 16'($urandom_range(0, 6));
            stop      = ($urandom % 40) == 0;
            byteValid = ($urandom % 3) != 0;
            byteIn    = 8'($urandom);
            rst       = ($urandom % 400) == 0;
            tick();
        end
        start = 1'b0; stop = 1'b0; byteValid = 1'b0; rst = 1'b1;
        tick();
        check_reset_outputs("final_rst");
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
